div_iter: RTL
=============

// Module: div_iter
// PURPOSE
//  Multi-cycle radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU in the EXE stage.
//  Each iteration uses the slt-style subtract (a + ~b + 1); the carry-out is the
//  "not less than" decision that keeps or restores the partial remainder.
//  Sits beside the ALU; the pipeline stalls EXE while busy, using valid/ready handshakes.
// PARAMETERS
//  DATA_W  32  operand/result width; CNT_W = $clog2(DATA_W)+1, derived locally
// PORTS
//  clk          in   1       single clock; all state on posedge
//  reset        in   1       asynchronous, active-high; clears all state
//  div_valid    in   1       request valid
//  div_ready    out  1       request accepted when div_valid & div_ready
//  div_op       in   2       [0]=signed (W) vs unsigned (WU); [1]=remainder (MOD) vs quotient (DIV)
//  div_src1     in   DATA_W  dividend (rj)
//  div_src2     in   DATA_W  divisor (rk)
//  div_cancel   in   1       flush from WB exception/ertn; aborts any operation
//  res_valid    out  1       result valid, held until res_ready
//  res_ready    in   1       consumer accepts result
//  div_result   out  DATA_W  quotient or remainder per latched div_op[1]
// BEHAVIOUR
//  Reset: state=IDLE, div_ready=1, res_valid=0, div_result=0, counters/regs=0.
//  FSM: IDLE -(div_valid)-> CALC -(cnt==DATA_W)-> DONE -(res_ready)-> IDLE.
//   - div_ready=1 only in IDLE; no pipelined second request.
//   - Accept cycle (T0): latch op, |src1|,|src2| (signed mode: two's-complement abs),
//     result signs: q_neg = s1^s2, r_neg = s1 (signed only); rem=0, cnt=0.
//   - CALC T1..T32: {rem,quo} <<= 1 shifting in dividend MSB; trial = rem - divisor
//     via a + ~b + 1 on DATA_W+1 bits; carry-out=1 -> rem=trial, quo[0]=1; else restore, quo[0]=0.
//   - T33: enter DONE, apply sign fixup, res_valid=1; div_result stable until handshake.
//   - DONE & res_ready: res_valid drops next cycle; IDLE; new request accepted the cycle after.
//  Latency: 33 cycles from accept to res_valid (fixed, no early termination).
//  Special cases (bypass CALC, go to DONE at T1, latency 1):
//   - divisor==0: quotient=all ones, remainder=dividend (both signed and unsigned).
//   - signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
//  Sign rules: remainder takes the dividend's sign; quotient truncates toward zero.
//  div_cancel: in any state, next state IDLE, res_valid=0, no result is issued; cancel
//   overrides a same-cycle div_valid (request not accepted) and res_ready.
//  res_ready held low in DONE: block stays in DONE with result unchanged indefinitely.
//  Reset mid-CALC: immediate return to reset values; no partial result is observable.
// STRUCTURE
//  Shared package/header (mycpu_defs): DIV_OP_SIGNED=0, DIV_OP_MOD=1 bit indices,
//   FSM state encodings S_IDLE/S_CALC/S_DONE (2-bit).
//  One sub-module: div_step. Combinational, DATA_W+1-bit trial subtract returning
//   {cout, diff}. Same adder form as the ALU comparator. Everything else in div_iter.
// TESTING
//  1 unsigned: op=00 src1=100 src2=7, res_ready=1 -> res_valid at T33, result=14; op=10 -> 2.
//  2 signed: op=01 src1=-7 (0xFFFFFFF9) src2=2 -> 0xFFFFFFFD (-3); op=11 -> 0xFFFFFFFF (-1).
//  3 div by zero: src2=0, src1=0x1234 -> DIV=0xFFFFFFFF, MOD=0x1234, res_valid at T1.
//  4 overflow: op=01 src1=0x80000000 src2=0xFFFFFFFF -> 0x80000000; op=11 -> 0.
//  5 backpressure/cancel: res_ready=0 for 10 cycles in DONE -> result held, div_ready=0;
//    assert div_cancel at T15 of CALC -> IDLE next cycle, res_valid never rises.
//  6 reset: assert reset mid-CALC (async, off-edge) -> outputs at reset values immediately;
//    back-to-back random ops vs reference model, 10k vectors, zero mismatches.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: op-bit indices and FSM encodings.
package div_iter_pkg;

    localparam int unsigned DIV_OP_SIGNED = 0;
    localparam int unsigned DIV_OP_MOD    = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division trial subtract: a + ~b + 1, carry-out set when a >= b.
module div_step #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         cout,
    output logic [W-1:0] diff
);

    assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU.
// Fixed 33-cycle latency; divide-by-zero and signed overflow resolve in one cycle.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic [1:0]        div_op,
    input  logic [DATA_W-1:0] div_src1,
    input  logic [DATA_W-1:0] div_src2,
    input  logic              div_cancel,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] div_result
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    div_state_e        state_q, state_d;
    logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mod_q, mod_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic              bypass_q, bypass_d, ready_d, valid_d;

    logic              signed_op, s1_neg, s2_neg, ovf, div_zero;
    logic [DATA_W-1:0] src1_abs, src2_abs;
    logic [DATA_W:0]   step_a, step_b, step_diff;
    logic              step_cout;

    // Operand conditioning for the accept cycle
    assign signed_op = div_op[DIV_OP_SIGNED];
    assign s1_neg    = signed_op & div_src1[DATA_W-1];
    assign s2_neg    = signed_op & div_src2[DATA_W-1];
    assign src1_abs  = s1_neg ? (~div_src1) + DATA_W'(1) : div_src1;
    assign src2_abs  = s2_neg ? (~div_src2) + DATA_W'(1) : div_src2;
    assign div_zero  = (div_src2 == '0);
    assign ovf       = signed_op & (div_src1 == {1'b1, {(DATA_W-1){1'b0}}}) & (&div_src2);

    // Partial remainder is widened by one bit so the shifted value never overflows
    assign step_a = {rem_q, quo_q[DATA_W-1]};
    assign step_b = {1'b0, dvsr_q};

    div_step #(.W(DATA_W + 1)) u_step (
        .a    (step_a),
        .b    (step_b),
        .cout (step_cout),
        .diff (step_diff)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        mod_d    = mod_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        bypass_d = bypass_q;
        result_d = div_result;

        case (state_q)
            S_IDLE: begin
                if (div_valid) begin
                    state_d  = S_CALC;
                    mod_d    = div_op[DIV_OP_MOD];
                    q_neg_d  = s1_neg ^ s2_neg;
                    r_neg_d  = s1_neg;
                    dvsr_d   = src2_abs;
                    quo_d    = src1_abs;
                    rem_d    = '0;
                    cnt_d    = '0;
                    bypass_d = div_zero | ovf;
                    // Special cases preload final magnitudes and skip sign fixup
                    if (div_zero) begin
                        quo_d   = '1;
                        rem_d   = div_src1;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                    end else if (ovf) begin
                        quo_d   = div_src1;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                    end
                end
            end
            S_CALC: begin
                if (bypass_q || (cnt_q == CNT_W'(DATA_W))) begin
                    state_d = S_DONE;
                    if (mod_q)
                        result_d = r_neg_q ? (~rem_q) + DATA_W'(1) : rem_q;
                    else
                        result_d = q_neg_q ? (~quo_q) + DATA_W'(1) : quo_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (step_cout) begin
                        rem_d = step_diff[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = step_a[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            S_DONE: begin
                if (res_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over any same-cycle request or handshake
        if (div_cancel) begin
            state_d  = S_IDLE;
            result_d = div_result;
        end

        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            cnt_q      <= '0;
            mod_q      <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            bypass_q   <= 1'b0;
            div_ready  <= 1'b1;
            res_valid  <= 1'b0;
            div_result <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            cnt_q      <= cnt_d;
            mod_q      <= mod_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            bypass_q   <= bypass_d;
            div_ready  <= ready_d;
            res_valid  <= valid_d;
            div_result <= result_d;
        end
    end

endmodule
